eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_tx_arb.sv | 193 +++++++++++++++++++
 tb/tb_eth_tx_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// Two-requester round-robin GMII transmit arbiter: preamble, SFD, payload and inter-frame gap.
// Define ETH_TX_ARB_CRC_EN to append the IEEE 802.3 CRC-32 FCS after the payload.
module eth_tx_arb #(
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned IFG_LEN = 12
) (
    input  logic       i_tx_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [7:0] i_data0,
    input  logic [7:0] i_data1,
    input  logic       i_last0,
    input  logic       i_last1,
    output logic       o_rd0,
    output logic       o_rd1,
    output logic       o_tx_en,
    output logic [7:0] o_tx_data,
    output logic       o_busy,
    output logic       o_grant,
    output logic       o_underrun
);

    localparam logic [7:0] PRE_END  = 8'(PRE_LEN - 1);
    localparam logic [7:0] IFG_END  = 8'(IFG_LEN - 1);
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_IFG
`ifdef ETH_TX_ARB_CRC_EN
        , S_FCS
`endif
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_last_gnt;
    logic       r_grant;
    logic       r_tx_en;
    logic [7:0] r_tx_data;
    logic       r_busy;
    logic       r_underrun;

    logic       w_req;
    logic       w_last;
    logic [7:0] w_data;
    logic       w_take;
    logic       w_win;

    // Only the owning requester is visible to the datapath.
    assign w_req  = r_grant ? i_req1  : i_req0;
    assign w_last = r_grant ? i_last1 : i_last0;
    assign w_data = r_grant ? i_data1 : i_data0;
    assign w_take = (r_state == S_DATA) && w_req && !i_rst;
    assign w_win  = (i_req0 && i_req1) ? !r_last_gnt : i_req1;

    assign o_rd0      = w_take && !r_grant;
    assign o_rd1      = w_take && r_grant;
    assign o_tx_en    = r_tx_en;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;
    assign o_grant    = r_grant;
    assign o_underrun = r_underrun;

`ifdef ETH_TX_ARB_CRC_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    assign w_crc_next = crc32_byte(r_crc, w_data);
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
`endif

    // Outputs are registered one cycle behind the state that produces them.
    always_ff @(posedge i_tx_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_last_gnt <= 1'b1;
            r_grant    <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
`ifdef ETH_TX_ARB_CRC_EN
            r_crc      <= 32'hFFFFFFFF;
`endif
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx_en   <= 1'b0;
                    r_tx_data <= 8'h00;
                    if (i_en && (i_req0 || i_req1)) begin
                        r_grant    <= w_win;
                        r_last_gnt <= w_win;
                        r_busy     <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_state    <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= PRE_BYTE;
                    if (r_cnt == PRE_END) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_SFD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SFD: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= SFD_BYTE;
                    r_state   <= S_DATA;
`ifdef ETH_TX_ARB_CRC_EN
                    r_crc     <= 32'hFFFFFFFF;
`endif
                end
                S_DATA: begin
                    if (w_req) begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= w_data;
`ifdef ETH_TX_ARB_CRC_EN
                        r_crc     <= w_crc_next;
`endif
                        if (w_last) begin
                            r_cnt <= 8'd0;
`ifdef ETH_TX_ARB_CRC_EN
                            r_state <= S_FCS;
`else
                            r_state <= S_IFG;
`endif
                        end
                    end else begin
                        r_tx_en    <= 1'b0;
                        r_tx_data  <= 8'h00;
                        r_underrun <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_state    <= S_IFG;
                    end
                end
`ifdef ETH_TX_ARB_CRC_EN
                S_FCS: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= w_fcs_byte;
                    if (r_cnt == 8'd3) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_IFG;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
`endif
                // Gap cycles count only once the final byte has left the output register.
                S_IFG: begin
                    r_tx_en   <= 1'b0;
                    r_tx_data <= 8'h00;
                    if (!r_tx_en) begin
                        if (r_cnt == IFG_END) begin
                            r_cnt   <= 8'd0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_tx_en   <= 1'b0;
                    r_tx_data <= 8'h00;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: FWFT source queues, per-cycle output log, frame-level scoreboard.
// Build with ETH_TX_ARB_CRC_EN defined to also cover the FCS path.
module tb_eth_tx_arb;

    localparam int unsigned PRE = 7;
    localparam int unsigned IFG = 12;

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_req0, i_req1, i_last0, i_last1;
    logic [7:0] i_data0, i_data1;
    logic       o_rd0, o_rd1, o_tx_en, o_busy, o_grant, o_underrun;
    logic [7:0] o_tx_data;

    always #4 clk = ~clk;

    eth_tx_arb #(.PRE_LEN(PRE), .IFG_LEN(IFG)) dut (
        .i_tx_clk(clk), .i_rst(i_rst), .i_en(i_en),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_data0(i_data0), .i_data1(i_data1),
        .i_last0(i_last0), .i_last1(i_last1),
        .o_rd0(o_rd0), .o_rd1(o_rd1),
        .o_tx_en(o_tx_en), .o_tx_data(o_tx_data),
        .o_busy(o_busy), .o_grant(o_grant), .o_underrun(o_underrun)
    );

    typedef struct packed {
        logic       en;
        logic [7:0] d;
        logic       busy;
        logic       grant;
        logic       und;
    } snap_t;

    typedef struct {
        logic en;
        logic r0;
        logic r1;
        logic e_busy;
        logic e_grant;
    } vec_t;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    snap_t      log_q[$];
    int         exp_len[$];
    logic       exp_g[$];
    logic [7:0] exp_b[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         rd0_cnt = 0;
    int         rd1_cnt = 0;
    logic       p0, p1;
    bit         rand_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

`ifdef ETH_TX_ARB_CRC_EN
    function automatic logic [31:0] crc32(input logic [7:0] p[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (p[k]) begin
            c = c ^ {24'h000000, p[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction
`endif

    // Expected frame on the wire: preamble, SFD, payload, optional FCS.
    task automatic add_exp(input logic g, input logic [7:0] p[$], input bit with_fcs);
        int n = 0;
        exp_g.push_back(g);
        for (int k = 0; k < int'(PRE); k++) begin exp_b.push_back(8'h55); n++; end
        exp_b.push_back(8'hD5); n++;
        foreach (p[k]) begin exp_b.push_back(p[k]); n++; end
`ifdef ETH_TX_ARB_CRC_EN
        if (with_fcs) begin
            logic [31:0] c = crc32(p);
            for (int k = 0; k < 4; k++) begin exp_b.push_back(c[8*k +: 8]); n++; end
        end
`else
        if (with_fcs) n = n + 0;
`endif
        exp_len.push_back(n);
    endtask

    task automatic load(input int k, input logic [7:0] p[$], input bit last);
        foreach (p[i]) begin
            logic [8:0] w = {last && (i == p.size() - 1), p[i]};
            if (k == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    // One clock: drive FWFT view at negedge, note strobes before posedge, pop, log at next negedge.
    task automatic cycle();
        if (q0.size() != 0) begin i_req0 = 1'b1; i_data0 = q0[0][7:0]; i_last0 = q0[0][8]; end
        else begin i_req0 = 1'b0; i_data0 = 8'h00; i_last0 = 1'b0; end
        if (q1.size() != 0) begin i_req1 = 1'b1; i_data1 = q1[0][7:0]; i_last1 = q1[0][8]; end
        else begin i_req1 = 1'b0; i_data1 = 8'h00; i_last1 = 1'b0; end
        if (rand_en) i_en = ($urandom_range(0, 3) != 0);
        #1;
        p0 = o_rd0;
        p1 = o_rd1;
        @(posedge clk);
        if (p0 && q0.size() != 0) begin void'(q0.pop_front()); rd0_cnt++; end
        if (p1 && q1.size() != 0) begin void'(q1.pop_front()); rd1_cnt++; end
        @(negedge clk);
        log_q.push_back('{en: o_tx_en, d: o_tx_data, busy: o_busy, grant: o_grant, und: o_underrun});
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        i_rst = 1'b1;
        cycle();
        cycle();
        i_rst = 1'b0;
        chk("reset_outputs", int'({log_q[$].en, log_q[$].d, log_q[$].busy, log_q[$].grant, log_q[$].und}), 0);
        log_q.delete();
        rd0_cnt = 0;
        rd1_cnt = 0;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !log_q[$].busy) && n < max);
        chk("idle_timeout", int'(n >= max), 0);
    endtask

    task automatic close_frame(input logic [7:0] cur[$], input logic g);
        int el, bad;
        logic eg;
        logic [7:0] b;
        if (exp_len.size() == 0) begin
            chk("unexpected_frame_len", cur.size(), 0);
            return;
        end
        el = exp_len.pop_front();
        eg = exp_g.pop_front();
        chk("frame_len", cur.size(), el);
        chk("frame_grant", int'(g), int'(eg));
        bad = 0;
        for (int k = 0; k < el; k++) begin
            b = exp_b.pop_front();
            if (k >= cur.size() || cur[k] !== b) bad++;
        end
        chk("frame_bytes_bad", bad, 0);
    endtask

    // Split the log into frames (tx_en runs) and check each frame and its trailing gap.
    task automatic analyze(input int exp_und);
        logic [7:0] cur[$];
        logic in_f = 1'b0;
        logic g = 1'b0;
        int und = 0;
        int gap, j;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].und) und++;
            if (log_q[i].en) begin
                if (!in_f) begin in_f = 1'b1; cur.delete(); g = log_q[i].grant; end
                cur.push_back(log_q[i].d);
            end else if (in_f) begin
                in_f = 1'b0;
                close_frame(cur, g);
                gap = 0;
                j = i;
                while (j < log_q.size() && !log_q[j].en && log_q[j].busy) begin gap++; j++; end
                chk("ifg_gap", gap, int'(IFG));
            end
        end
        chk("frame_open", int'(in_f), 0);
        chk("frames_missing", exp_len.size(), 0);
        chk("underruns", und, exp_und);
        exp_len.delete(); exp_g.delete(); exp_b.delete();
        log_q.delete();
    endtask

    initial begin
        vec_t tbl[6];
        logic [7:0] p[$];
        logic [7:0] p2[$];
        int n, idx;
        logic seen;

        tbl[0] = '{en: 1'b0, r0: 1'b0, r1: 1'b1, e_busy: 1'b0, e_grant: 1'b0};
        tbl[1] = '{en: 1'b1, r0: 1'b0, r1: 1'b1, e_busy: 1'b1, e_grant: 1'b1};
        tbl[2] = '{en: 1'b1, r0: 1'b1, r1: 1'b1, e_busy: 1'b1, e_grant: 1'b0};
        tbl[3] = '{en: 1'b1, r0: 1'b1, r1: 1'b0, e_busy: 1'b1, e_grant: 1'b0};
        tbl[4] = '{en: 1'b1, r0: 1'b0, r1: 1'b0, e_busy: 1'b0, e_grant: 1'b0};
        tbl[5] = '{en: 1'b0, r0: 1'b1, r1: 1'b1, e_busy: 1'b0, e_grant: 1'b0};

        i_rst = 1'b1; i_en = 1'b0;
        i_req0 = 1'b0; i_req1 = 1'b0; i_data0 = 8'h00; i_data1 = 8'h00;
        i_last0 = 1'b0; i_last1 = 1'b0;
        @(negedge clk);

        // First-grant decisions straight out of reset.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            i_en = tbl[t].en;
            if (tbl[t].r0) q0.push_back({1'b1, 8'h11});
            if (tbl[t].r1) q1.push_back({1'b1, 8'h22});
            cycle();
            chk($sformatf("tbl%0d_busy", t), int'(log_q[$].busy), int'(tbl[t].e_busy));
            chk($sformatf("tbl%0d_grant", t), int'(log_q[$].grant), int'(tbl[t].e_grant));
            chk($sformatf("tbl%0d_txen", t), int'(log_q[$].en), 0);
        end

        // Single 3-byte frame from requester 0.
        do_reset();
        i_en = 1'b1;
        p = {8'h01, 8'h02, 8'h03};
        load(0, p, 1'b1);
        add_exp(1'b0, p, 1'b1);
        cycle();
        chk("single_busy_after_grant", int'(log_q[$].busy), 1);
        chk("single_txen_first_pre", int'(log_q[$].en), 0);
        run_until_idle(200);
        chk("single_rd0_count", rd0_cnt, 3);
        chk("single_rd1_count", rd1_cnt, 0);
        analyze(0);

        // Fairness: both sides hold three 1-byte frames.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            p  = {8'(8'hA0 + k)};
            p2 = {8'(8'hB0 + k)};
            load(0, p, 1'b1);
            load(1, p2, 1'b1);
            add_exp(1'b0, p, 1'b1);
            add_exp(1'b1, p2, 1'b1);
        end
        run_until_idle(400);
        analyze(0);

        // Underrun: two bytes, no last marker.
        do_reset();
        p = {8'hA1, 8'hA2};
        load(0, p, 1'b0);
        add_exp(1'b0, p, 1'b0);
        run_until_idle(200);
        idx = -1;
        foreach (log_q[i]) if (log_q[i].und && idx < 0) idx = i;
        chk("underrun_found", int'(idx > 0), 1);
        if (idx > 0) begin
            chk("underrun_txen_low", int'(log_q[idx].en), 0);
            chk("underrun_prev_txen", int'(log_q[idx - 1].en), 1);
        end
        analyze(1);

        // Reset while the 5th payload byte of requester 0 is presented.
        do_reset();
        p.delete();
        for (int k = 0; k < 10; k++) p.push_back(8'(8'h30 + k));
        load(0, p, 1'b1);
        n = 0;
        while (rd0_cnt < 4 && n < 100) begin cycle(); n++; end
        chk("midreset_reach_timeout", int'(n >= 100), 0);
        i_rst = 1'b1;
        cycle();
        chk("midreset_rd0_gated", int'(p0), 0);
        chk("midreset_outputs", int'({log_q[$].en, log_q[$].d, log_q[$].busy, log_q[$].grant, log_q[$].und}), 0);
        i_rst = 1'b0;
        q0.delete(); q1.delete(); log_q.delete();
        rd0_cnt = 0; rd1_cnt = 0;
        p = {8'h61}; p2 = {8'h62};
        load(0, p, 1'b1); load(1, p2, 1'b1);
        add_exp(1'b0, p, 1'b1); add_exp(1'b1, p2, 1'b1);
        cycle();
        chk("midreset_tie_grant", int'(log_q[$].grant), 0);
        chk("midreset_tie_busy", int'(log_q[$].busy), 1);
        run_until_idle(400);
        analyze(0);

        // Enable gating and enable drop mid-frame.
        do_reset();
        i_en = 1'b0;
        p = {8'hC1, 8'hC2, 8'hC3};
        load(1, p, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin cycle(); seen = seen | log_q[$].busy; end
        chk("en_low_busy", int'(seen), 0);
        chk("en_low_rd1", rd1_cnt, 0);
        log_q.delete();
        add_exp(1'b1, p, 1'b1);
        i_en = 1'b1;
        cycle();
        chk("en_rise_busy", int'(log_q[$].busy), 1);
        chk("en_rise_grant", int'(log_q[$].grant), 1);
        i_en = 1'b0;
        run_until_idle(200);
        chk("en_drop_rd1", rd1_cnt, 3);
        analyze(0);

`ifdef ETH_TX_ARB_CRC_EN
        // 60 zero bytes with FCS.
        do_reset();
        i_en = 1'b1;
        p.delete();
        for (int k = 0; k < 60; k++) p.push_back(8'h00);
        load(0, p, 1'b1);
        add_exp(1'b0, p, 1'b1);
        run_until_idle(400);
        analyze(0);
`endif

        // Random frame mixes with a toggling enable, against a round-robin model.
        for (int it = 0; it < 3; it++) begin
            int nf0, nf1, i0, i1, ln;
            int l0[$];
            int l1[$];
            logic [7:0] b0[$];
            logic [7:0] b1[$];
            logic lastg, g;
            do_reset();
            nf0 = $urandom_range(1, 4);
            nf1 = $urandom_range(0, 4);
            for (int f = 0; f < nf0; f++) begin
                ln = $urandom_range(1, 6);
                p.delete();
                for (int k = 0; k < ln; k++) p.push_back(8'($urandom));
                load(0, p, 1'b1);
                l0.push_back(ln);
                foreach (p[k]) b0.push_back(p[k]);
            end
            for (int f = 0; f < nf1; f++) begin
                ln = $urandom_range(1, 6);
                p.delete();
                for (int k = 0; k < ln; k++) p.push_back(8'($urandom));
                load(1, p, 1'b1);
                l1.push_back(ln);
                foreach (p[k]) b1.push_back(p[k]);
            end
            i0 = 0; i1 = 0; lastg = 1'b1;
            while (i0 < nf0 || i1 < nf1) begin
                if (i0 < nf0 && i1 < nf1) g = !lastg;
                else g = (i0 < nf0) ? 1'b0 : 1'b1;
                lastg = g;
                p.delete();
                if (!g) begin
                    ln = l0.pop_front();
                    for (int k = 0; k < ln; k++) p.push_back(b0.pop_front());
                    i0++;
                end else begin
                    ln = l1.pop_front();
                    for (int k = 0; k < ln; k++) p.push_back(b1.pop_front());
                    i1++;
                end
                add_exp(g, p, 1'b1);
            end
            rand_en = 1'b1;
            run_until_idle(3000);
            rand_en = 1'b0;
            i_en = 1'b1;
            analyze(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
